sevenseg_capture: RTL

Receive-side decoder for the multiplexed seven-segment display bus. It samples the active-low anode and cathode lines driven by the display scan logic and filters out scan transitions. It decodes each stable segment pattern back to a hex nibble and reassembles the four digits into a 16-bit value with a one-cycle valid strobe. It sits beside the top level, on the same clock, so the board-level display output can be checked and read back in hardware and in simulation.

---
 rtl/sevenseg_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_capture.sv
// sevenseg_capture: receive-side decoder for the multiplexed seven-segment bus.
// Samples active-low {an,seg}, accepts a digit after STABLE_CYCLES of stable
// input, decodes it to a hex nibble and emits a 16-bit frame once all four
// digit positions have been seen.
// Optional feature macro: SEVSEG_ERRCNT_EN (saturating error counter on err_cnt).
module sevenseg_capture #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        err,
  output logic [7:0]  err_cnt
);

  localparam int unsigned IN_W  = 11;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned N_DIG = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ACC = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_EMIT    = 1'b1
  } state_t;

  // Map an active-low segment code to {legal, nibble}; anything else is illegal.
  function automatic logic [DIG_W:0] seg_decode(input logic [6:0] code);
    logic [DIG_W:0] r;
    r = '0;
    case (code)
      7'h40: r = 5'h10;
      7'h79: r = 5'h11;
      7'h24: r = 5'h12;
      7'h30: r = 5'h13;
      7'h19: r = 5'h14;
      7'h12: r = 5'h15;
      7'h02: r = 5'h16;
      7'h78: r = 5'h17;
      7'h00: r = 5'h18;
      7'h10: r = 5'h19;
      7'h08: r = 5'h1A;
      7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;
      7'h21: r = 5'h1D;
      7'h06: r = 5'h1E;
      7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [IN_W-1:0]              in_c;
  logic [IN_W-1:0]              s_q;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         accept_c;
  logic [DIG_W:0]               dec_c;
  logic                         seg_legal_c;
  logic [DIG_W-1:0]             nibble_c;
  logic                         an_one_c;
  logic [1:0]                   an_idx_c;
  logic                         blank_c;

  state_t                       state_q, state_d;
  logic [N_DIG-1:0][DIG_W-1:0]  digits_q, digits_d;
  logic [N_DIG-1:0]             seen_q, seen_d;
  logic [N_DIG-1:0]             seen_upd;
  logic [15:0]                  value_q, value_d;
  logic                         err_q, err_d;

  assign in_c        = {an, seg};
  assign accept_c    = (in_c == s_q) && (cnt_q == CNT_ACC);
  assign dec_c       = seg_decode(seg);
  assign seg_legal_c = dec_c[DIG_W];
  assign nibble_c    = dec_c[DIG_W-1:0];
  assign blank_c     = (an == 4'b1111);

  // Single active anode to digit index; multiple or no zeros are not single.
  always_comb begin
    an_one_c = 1'b1;
    an_idx_c = 2'd0;
    case (an)
      4'b1110: an_idx_c = 2'd0;
      4'b1101: an_idx_c = 2'd1;
      4'b1011: an_idx_c = 2'd2;
      4'b0111: an_idx_c = 2'd3;
      default: an_one_c = 1'b0;
    endcase
  end

  // Stability counter: restart on any change, park at STABLE_CYCLES so a held
  // pattern produces exactly one accept.
  always_comb begin
    cnt_d = cnt_q;
    if (in_c != s_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Input sample register and stability counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_q   <= '1;
      cnt_q <= '0;
    end else begin
      s_q   <= in_c;
      cnt_q <= cnt_d;
    end
  end

  // Frame FSM next-state and datapath: classify accepts, collect digits, emit.
  always_comb begin
    state_d  = ST_COLLECT;
    digits_d = digits_q;
    seen_d   = seen_q;
    seen_upd = seen_q;
    value_d  = value_q;
    err_d    = 1'b0;
    if (accept_c && !blank_c) begin
      if (!an_one_c || !seg_legal_c) begin
        err_d  = 1'b1;
        seen_d = '0;
      end else begin
        digits_d[an_idx_c] = nibble_c;
        seen_upd           = seen_q | (N_DIG'(1) << an_idx_c);
        if (seen_upd == {N_DIG{1'b1}}) begin
          value_d = digits_d;
          seen_d  = '0;
          state_d = ST_EMIT;
        end else begin
          seen_d = seen_upd;
        end
      end
    end
  end

  // Frame FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_COLLECT;
      digits_q <= '0;
      seen_q   <= '0;
      value_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      seen_q   <= seen_d;
      value_q  <= value_d;
      err_q    <= err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = (state_q == ST_EMIT);
  assign err         = err_q;

`ifdef SEVSEG_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating error counter, advanced together with the err pulse register.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  // Error counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule
